// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receive FSM states and default framing
// constants common to the start-bit detector and the character deserializer.
package serial_pkg;

    localparam int SERIAL_SAMPLES_PER_BIT = 16;
    localparam int SERIAL_DATA_BITS       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2,
        WAIT  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Modulo-N bit-cell timer: counts 0..N-1 and wraps, with a one-cycle tick
// on the cycle the count sits at N-1.
module bit_timer #(
    parameter int N = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    assign tick = !clear && (count_q == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/char_deserializer.sv
// Serial receive deserializer: times bit cells after a validated start bit,
// assembles the character LSB first, checks the stop bit and hands it off.
module char_deserializer
    import serial_pkg::*;
#(
    parameter int   DATA_BITS       = SERIAL_DATA_BITS,
    parameter int   SAMPLES_PER_BIT = SERIAL_SAMPLES_PER_BIT,
    parameter logic STOP_LEVEL      = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 data,
    input  logic                 reading_char,
    input  logic                 char_ack,
    output logic [DATA_BITS-1:0] char_out,
    output logic                 char_valid,
    output logic                 char_done,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int               IDX_W    = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   stop_bit_q, stop_bit_d;
    logic [DATA_BITS-1:0]   char_out_q, char_out_d;
    logic                   char_valid_q, char_valid_d;
    logic                   char_done_q, char_done_d;
    logic                   framing_error_q, framing_error_d;
    logic                   overrun_q, overrun_d;
    logic                   timer_clear;
    logic                   tick;

    bit_timer #(
        .N (SAMPLES_PER_BIT)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_idx_d       = bit_idx_q;
        stop_pend_d     = 1'b0;
        stop_bit_d      = stop_bit_q;
        char_out_d      = char_out_q;
        char_valid_d    = char_valid_q;
        char_done_d     = 1'b0;
        framing_error_d = 1'b0;
        overrun_d       = overrun_q;
        timer_clear     = 1'b1;

        if (char_ack && char_valid_q) begin
            char_valid_d = 1'b0;
        end

        // The stop sample is judged one cycle after capture so every
        // frame-level output changes together on a registered edge.
        if (stop_pend_q) begin
            char_done_d = 1'b1;
            if (stop_bit_q == STOP_LEVEL) begin
                char_out_d   = shift_q;
                char_valid_d = 1'b1;
                if (char_valid_q && !char_ack) begin
                    overrun_d = 1'b1;
                end
            end else begin
                framing_error_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (reading_char) begin
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                timer_clear = 1'b0;
                if (tick) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bit_idx_q == IDX_W'(i)) begin
                            shift_d[i] = data;
                        end
                    end
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                timer_clear = 1'b0;
                if (tick) begin
                    stop_bit_d  = data;
                    stop_pend_d = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // Hold off until the detector drops its level, so a stale
                // reading_char cannot start a phantom frame.
                if (!reading_char) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            bit_idx_q       <= '0;
            stop_pend_q     <= 1'b0;
            stop_bit_q      <= 1'b0;
            char_out_q      <= '0;
            char_valid_q    <= 1'b0;
            char_done_q     <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            bit_idx_q       <= bit_idx_d;
            stop_pend_q     <= stop_pend_d;
            stop_bit_q      <= stop_bit_d;
            char_out_q      <= char_out_d;
            char_valid_q    <= char_valid_d;
            char_done_q     <= char_done_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    assign char_out      = char_out_q;
    assign char_valid    = char_valid_q;
    assign char_done     = char_done_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_char_deserializer.sv
// Scoreboard bench for char_deserializer: frames push expected results, a
// monitor pops and compares whenever char_done is presented.
module tb_char_deserializer;
    import serial_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       data;
    logic       reading_char;
    logic       char_ack;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_done;
    logic       framing_error;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        logic [7:0] out;
        logic       valid;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];

    char_deserializer #(
        .DATA_BITS       (8),
        .SAMPLES_PER_BIT (16),
        .STOP_LEVEL      (1'b0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data          (data),
        .reading_char  (reading_char),
        .char_ack      (char_ack),
        .char_out      (char_out),
        .char_valid    (char_valid),
        .char_done     (char_done),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every char_done pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                if (char_done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got char_done=1, expected none (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                        chk("char_out", 32'(char_out), 32'(e.out));
                        chk("char_valid", 32'(char_valid), 32'(e.valid));
                        chk("framing_error", 32'(framing_error), 32'(e.ferr));
                        chk("overrun", 32'(overrun), 32'(e.ovr));
                    end
                end else if (framing_error === 1'b1) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stray_ferr: got framing_error=1 without char_done, expected 0 (cycle %0d)", cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    function automatic logic line_level(input int k, input logic [7:0] b, input logic stop_lvl);
        int c;
        c = (k - 9) / 16;
        if (k <= 8) return 1'b1;
        if (c < 8) return b[c];
        if (c == 8) return stop_lvl;
        return 1'b0;
    endfunction

    // k indexes the edge T+k at which the driven values are sampled; each
    // bit is held for a full cell centred on its mid-cell sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int hold_extra,
                              input bit drop_early, input int ack_at, input int reset_at,
                              input logic [7:0] e_out, input logic e_valid,
                              input logic e_ferr, input logic e_ovr);
        int   t0;
        exp_t e;
        @(posedge clock);
        #1;
        reading_char = 1'b1;
        data         = 1'b1;
        @(posedge clock);
        #1;
        t0 = cyc;
        if (reset_at == 0) begin
            e.cyc   = t0 + 145;
            e.out   = e_out;
            e.valid = e_valid;
            e.ferr  = e_ferr;
            e.ovr   = e_ovr;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 150 + hold_extra; k++) begin
            data         = line_level(k, b, stop_lvl);
            reading_char = drop_early ? (k <= 30) : (k <= 146 + hold_extra);
            char_ack     = (k == ack_at);
            reset        = !(k == reset_at);
            if (reset_at > 0 && k > reset_at) begin
                reading_char = 1'b0;
                data         = 1'b0;
            end
            @(posedge clock);
            #1;
            if (k == reset_at) begin
                chk("rst_char_out", 32'(char_out), 32'h0);
                chk("rst_char_valid", 32'(char_valid), 32'h0);
                chk("rst_char_done", 32'(char_done), 32'h0);
                chk("rst_framing_error", 32'(framing_error), 32'h0);
                chk("rst_overrun", 32'(overrun), 32'h0);
                chk("rst_state", 32'(dut.state_q), 32'(IDLE));
            end
            if (reset_at > 0 && k >= reset_at + 3) break;
            if (!drop_early && reset_at == 0 && k == 146 + hold_extra)
                chk("wait_state", 32'(dut.state_q), 32'(WAIT));
        end
        reading_char = 1'b0;
        char_ack     = 1'b0;
        reset        = 1'b1;
        data         = 1'b0;
    endtask

    task automatic ack_pulse();
        char_ack = 1'b1;
        @(posedge clock);
        #1;
        char_ack = 1'b0;
        chk("valid_after_ack", 32'(char_valid), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        data         = 1'b0;
        reading_char = 1'b0;
        char_ack     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("init_char_out", 32'(char_out), 32'h0);
        chk("init_char_valid", 32'(char_valid), 32'h0);
        chk("init_char_done", 32'(char_done), 32'h0);
        chk("init_framing_error", 32'(framing_error), 32'h0);
        chk("init_overrun", 32'(overrun), 32'h0);
        chk("init_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b1;

        // Good frame, then framing error keeps previous char and valid low
        send_frame(8'hA5, 1'b0, 0, 1'b0, 0, 0, 8'hA5, 1'b1, 1'b0, 1'b0);
        ack_pulse();
        send_frame(8'hA5, 1'b1, 0, 1'b0, 0, 0, 8'hA5, 1'b0, 1'b1, 1'b0);

        // Overrun: two good frames without ack; overrun sticky after ack
        send_frame(8'h3C, 1'b0, 0, 1'b0, 0, 0, 8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 0, 1'b0, 0, 0, 8'hC3, 1'b1, 1'b0, 1'b1);
        ack_pulse();
        chk("overrun_sticky", 32'(overrun), 32'h1);

        // Ack collision on the output-load edge; first frame drops reading_char early
        do_reset();
        chk("overrun_cleared", 32'(overrun), 32'h0);
        send_frame(8'h11, 1'b0, 0, 1'b1, 0, 0, 8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h96, 1'b0, 0, 1'b0, 145, 0, 8'h96, 1'b1, 1'b0, 1'b0);

        // Reset mid-frame, then a clean frame
        send_frame(8'h77, 1'b0, 0, 1'b0, 0, 70, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 0, 1'b0, 0, 0, 8'h5A, 1'b1, 1'b0, 1'b0);
        ack_pulse();

        // Stale reading_char held 10 cycles past char_done must not re-trigger
        send_frame(8'h0F, 1'b0, 10, 1'b0, 0, 0, 8'h0F, 1'b1, 1'b0, 1'b0);
        repeat (200) @(posedge clock);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
